// File: rtl/coord_stream_gen.sv
`timescale 1ns/1ps
// Frame coordinate streamer: divides the view span into per-pixel steps once per
// frame, then walks the raster by accumulation and emits (x, y, re, im) beats.
module coord_stream_gen #(
   parameter int WORD_LENGTH   = 32,
   parameter int FRAC          = 28,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int ZOOM_W        = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ZOOM_W-1:0]      zoom,
   input  logic [WORD_LENGTH-1:0] real_center,
   input  logic [WORD_LENGTH-1:0] imag_center,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [10:0]            out_x,
   output logic [10:0]            out_y,
   output logic [WORD_LENGTH-1:0] out_real,
   output logic [WORD_LENGTH-1:0] out_imag,
   output logic                   out_last
);

   typedef enum logic [1:0] {IDLE, CALC, INIT, STREAM} state_t;

   localparam int CW = $clog2(WORD_LENGTH + 1);
   localparam logic [CW-1:0]        LAST_IT = CW'(WORD_LENGTH - 1);
   localparam logic [10:0]          X_MAX   = 11'(SCREEN_WIDTH - 1);
   localparam logic [10:0]          X_PEN   = 11'(SCREEN_WIDTH - 2);
   localparam logic [10:0]          Y_MAX   = 11'(SCREEN_HEIGHT - 1);
   localparam logic [WORD_LENGTH:0] DIV_W   = (WORD_LENGTH + 1)'(SCREEN_WIDTH);
   localparam logic [WORD_LENGTH:0] DIV_H   = (WORD_LENGTH + 1)'(SCREEN_HEIGHT);

   // (mult * one) >> z, formed two bits wider than a word before truncation
   function automatic logic [WORD_LENGTH-1:0] span(input int unsigned mult,
                                                   input logic [ZOOM_W-1:0] z);
      logic [WORD_LENGTH+1:0] base;
      base = (WORD_LENGTH + 2)'(mult) << FRAC;
      base = base >> z;
      return base[WORD_LENGTH-1:0];
   endfunction

   state_t                 state;
   logic [ZOOM_W-1:0]      zoom_q;
   logic [WORD_LENGTH-1:0] rc_q, ic_q, real_min;
   logic [CW-1:0]          it;
   // step_* hold the dividend at start and shift quotient bits in from the LSB
   logic [WORD_LENGTH-1:0] step_re, step_im, rem_re, rem_im;

   logic [WORD_LENGTH-1:0] rw_q, ih_q, real_lo, imag_hi;
   logic [WORD_LENGTH:0]   tr_re, tr_im;
   logic                   ge_re, ge_im;

   assign rw_q    = span(3, zoom_q);
   assign ih_q    = span(2, zoom_q);
   assign real_lo = rc_q - (rw_q >> 1);
   assign imag_hi = ic_q + (ih_q >> 1);

   assign tr_re = {rem_re, step_re[WORD_LENGTH-1]};
   assign tr_im = {rem_im, step_im[WORD_LENGTH-1]};
   assign ge_re = (tr_re >= DIV_W);
   assign ge_im = (tr_im >= DIV_H);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_real  <= '0;
         out_imag  <= '0;
         zoom_q    <= '0;
         rc_q      <= '0;
         ic_q      <= '0;
         real_min  <= '0;
         it        <= '0;
         step_re   <= '0;
         step_im   <= '0;
         rem_re    <= '0;
         rem_im    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               zoom_q  <= zoom;
               rc_q    <= real_center;
               ic_q    <= imag_center;
               it      <= '0;
               step_re <= span(3, zoom);
               step_im <= span(2, zoom);
               rem_re  <= '0;
               rem_im  <= '0;
               busy    <= 1'b1;
               state   <= CALC;
            end
            CALC: begin
               rem_re  <= ge_re ? WORD_LENGTH'(tr_re - DIV_W) : tr_re[WORD_LENGTH-1:0];
               rem_im  <= ge_im ? WORD_LENGTH'(tr_im - DIV_H) : tr_im[WORD_LENGTH-1:0];
               step_re <= {step_re[WORD_LENGTH-2:0], ge_re};
               step_im <= {step_im[WORD_LENGTH-2:0], ge_im};
               it      <= it + 1'b1;
               if (it == LAST_IT) state <= INIT;
            end
            INIT: begin
               real_min  <= real_lo;
               out_real  <= real_lo;
               out_imag  <= imag_hi;
               out_x     <= '0;
               out_y     <= '0;
               out_valid <= 1'b1;
               out_last  <= 1'b0;
               state     <= STREAM;
            end
            STREAM: if (out_valid && out_ready) begin
               if (out_x != X_MAX) begin
                  out_x    <= out_x + 1'b1;
                  out_real <= out_real + step_re;
                  out_last <= (out_x == X_PEN) && (out_y == Y_MAX);
               end else if (out_y != Y_MAX) begin
                  out_x    <= '0;
                  out_y    <= out_y + 1'b1;
                  out_real <= real_min;
                  out_imag <= out_imag - step_im;
               end else begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coord_stream_gen.sv
`timescale 1ns/1ps
// Directed bench: default-size instance for origin/latency/backpressure/reset,
// 6x4 instance for whole-frame, end-of-frame and start-while-busy behaviour.
module tb_coord_stream_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, start_s, out_ready, ready_s;
   logic [4:0]  zoom;
   logic [31:0] rc, ic;

   logic        busy, out_valid, out_last;
   logic [10:0] out_x, out_y;
   logic [31:0] out_real, out_imag;

   logic        busy_s, valid_s, last_s;
   logic [10:0] x_s, y_s;
   logic [31:0] real_s, imag_s;

   int n_cmp = 0;
   int n_err = 0;

   coord_stream_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .zoom(zoom),
      .real_center(rc), .imag_center(ic), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_real(out_real),
      .out_imag(out_imag), .out_last(out_last));

   coord_stream_gen #(.SCREEN_WIDTH(6), .SCREEN_HEIGHT(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .zoom(zoom),
      .real_center(rc), .imag_center(ic), .busy(busy_s), .out_valid(valid_s),
      .out_ready(ready_s), .out_x(x_s), .out_y(y_s), .out_real(real_s),
      .out_imag(imag_s), .out_last(last_s));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; start_s = 1'b0; out_ready = 1'b0; ready_s = 1'b0;
      zoom = '0; rc = '0; ic = '0;
      tick; tick;
      n_cmp++;
      if ({busy, out_valid, out_last} !== 3'b000) begin
         n_err++; $display("FAIL reset_flags got %b want 000", {busy, out_valid, out_last});
      end
      n_cmp++;
      if ({out_x, out_y} !== 22'd0) begin
         n_err++; $display("FAIL reset_xy got %0d,%0d want 0,0", out_x, out_y);
      end
      n_cmp++;
      if ({out_real, out_imag} !== 64'd0) begin
         n_err++; $display("FAIL reset_coord got %h %h want 0 0", out_real, out_imag);
      end
      n_cmp++;
      if ({busy_s, valid_s, last_s, x_s, y_s, real_s, imag_s} !== '0) begin
         n_err++; $display("FAIL reset_small got busy=%b valid=%b want 0", busy_s, valid_s);
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_origin;
      int cyc;
      zoom = 5'd0; rc = 32'hF800_0000; ic = 32'h0; out_ready = 1'b1;
      start = 1'b1; tick; start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL origin_busy got %b want 1", busy); end
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin tick; cyc++; end
      n_cmp++;
      if (cyc != 33) begin n_err++; $display("FAIL origin_latency got %0d want 33", cyc); end
      n_cmp++;
      if (out_x !== 11'd0 || out_y !== 11'd0 || out_real !== 32'hE000_0000 || out_imag !== 32'h1000_0000) begin
         n_err++; $display("FAIL origin_00 got (%0d,%0d) %h %h want (0,0) e0000000 10000000",
                           out_x, out_y, out_real, out_imag);
      end
      tick;
      n_cmp++;
      if (out_x !== 11'd1 || out_y !== 11'd0 || out_real !== 32'hE013_3333) begin
         n_err++; $display("FAIL origin_10 got (%0d,%0d) %h want (1,0) e0133333", out_x, out_y, out_real);
      end
      cyc = 0;
      while (!(out_x === 11'd0 && out_y === 11'd1) && cyc < 1000) begin tick; cyc++; end
      n_cmp++;
      if (cyc != 639) begin n_err++; $display("FAIL origin_row_len got %0d want 639", cyc); end
      n_cmp++;
      if (out_real !== 32'hE000_0000 || out_imag !== 32'h0FEE_EEEF) begin
         n_err++; $display("FAIL origin_01 got %h %h want e0000000 0feeeeef", out_real, out_imag);
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      rst_n = 1'b0; tick;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL midreset_abort got valid=%b busy=%b want 0 0", out_valid, busy);
      end
      rst_n = 1'b1;
      start = 1'b1; tick; start = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin tick; cyc++; end
      n_cmp++;
      if (out_x !== 11'd0 || out_y !== 11'd0 || out_real !== 32'hE000_0000 || out_imag !== 32'h1000_0000) begin
         n_err++; $display("FAIL midreset_restart got (%0d,%0d) %h %h want (0,0) e0000000 10000000",
                           out_x, out_y, out_real, out_imag);
      end
      rst_n = 1'b0; tick; rst_n = 1'b1; tick;
   endtask

   task automatic test_backpressure;
      int cyc, ex, ey, acc;
      logic [31:0] exp_re, exp_im, r0, r1;
      zoom = 5'd2; rc = 32'hF800_0000; ic = 32'h0; out_ready = 1'b0;
      start = 1'b1; tick; start = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin tick; cyc++; end
      ex = 0; ey = 0; acc = 0; r0 = '0; r1 = '0;
      for (int c = 0; c < 6000 && acc < 1290; c++) begin
         if (out_valid) begin
            exp_re = 32'hF200_0000 + 32'(ex) * 32'h0004_CCCC;
            exp_im = 32'h0400_0000 - 32'(ey) * 32'h0004_4444;
            n_cmp++;
            if (out_x !== 11'(ex) || out_y !== 11'(ey) || out_real !== exp_re || out_imag !== exp_im) begin
               n_err++; $display("FAIL bp_beat got (%0d,%0d) %h %h want (%0d,%0d) %h %h",
                                 out_x, out_y, out_real, out_imag, ex, ey, exp_re, exp_im);
            end
            if (ex == 0 && ey == 0) r0 = out_real;
            if (ex == 1 && ey == 0) r1 = out_real;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            acc++; ex++;
            if (ex == 640) begin ex = 0; ey++; end
         end
         tick;
      end
      n_cmp++;
      if (acc != 1290) begin n_err++; $display("FAIL bp_accepted got %0d want 1290", acc); end
      n_cmp++;
      if (r1 - r0 !== 32'h0004_CCCC) begin
         n_err++; $display("FAIL bp_step got %h want 0004cccc", r1 - r0);
      end
      rst_n = 1'b0; tick; rst_n = 1'b1; out_ready = 1'b0; tick;
   endtask

   task automatic test_full_frame;
      int cyc, ex, ey, beats;
      bit done;
      logic [31:0] exp_re, exp_im;
      zoom = 5'd0; rc = 32'hF800_0000; ic = 32'h0; ready_s = 1'b1;
      start_s = 1'b1; tick; start_s = 1'b0;
      cyc = 0;
      while (valid_s !== 1'b1 && cyc < 100) begin tick; cyc++; end
      n_cmp++;
      if (cyc != 33) begin n_err++; $display("FAIL frame_latency got %0d want 33", cyc); end
      ex = 0; ey = 0; beats = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (valid_s) begin
            exp_re = 32'hE000_0000 + 32'(ex) * 32'h0800_0000;
            exp_im = 32'h1000_0000 - 32'(ey) * 32'h0800_0000;
            n_cmp++;
            if (x_s !== 11'(ex) || y_s !== 11'(ey) || real_s !== exp_re || imag_s !== exp_im ||
                last_s !== (ex == 5 && ey == 3)) begin
               n_err++; $display("FAIL frame_beat got (%0d,%0d) %h %h last=%b want (%0d,%0d) %h %h",
                                 x_s, y_s, real_s, imag_s, last_s, ex, ey, exp_re, exp_im);
            end
            beats++;
            if (ex == 5 && ey == 3) done = 1'b1;
            ex++;
            if (ex == 6) begin ex = 0; ey++; end
         end
         tick;
      end
      n_cmp++;
      if (beats != 24) begin n_err++; $display("FAIL frame_beats got %0d want 24", beats); end
      n_cmp++;
      if ({busy_s, valid_s, last_s} !== 3'b000) begin
         n_err++; $display("FAIL frame_end got %b want 000", {busy_s, valid_s, last_s});
      end
      start_s = 1'b1; tick; start_s = 1'b0;
      n_cmp++;
      if (busy_s !== 1'b1) begin n_err++; $display("FAIL frame_restart got %b want 1", busy_s); end
      cyc = 0;
      while (busy_s === 1'b1 && cyc < 200) begin tick; cyc++; end
      n_cmp++;
      if (busy_s !== 1'b0) begin n_err++; $display("FAIL frame_second_done got %b want 0", busy_s); end
      tick;
   endtask

   task automatic test_start_ignored;
      int cyc, ex, ey, beats, extra;
      bit done;
      logic [31:0] exp_re, exp_im;
      zoom = 5'd0; rc = 32'hF800_0000; ic = 32'h0; ready_s = 1'b1;
      start_s = 1'b1; tick; start_s = 1'b0;
      cyc = 0;
      while (valid_s !== 1'b1 && cyc < 100) begin tick; cyc++; end
      ex = 0; ey = 0; beats = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (valid_s) begin
            exp_re = 32'hE000_0000 + 32'(ex) * 32'h0800_0000;
            exp_im = 32'h1000_0000 - 32'(ey) * 32'h0800_0000;
            n_cmp++;
            if (x_s !== 11'(ex) || y_s !== 11'(ey) || real_s !== exp_re || imag_s !== exp_im) begin
               n_err++; $display("FAIL busy_start_beat got (%0d,%0d) %h %h want (%0d,%0d) %h %h",
                                 x_s, y_s, real_s, imag_s, ex, ey, exp_re, exp_im);
            end
            beats++;
            if (ex == 5 && ey == 3) done = 1'b1;
            ex++;
            if (ex == 6) begin ex = 0; ey++; end
         end
         // held high from mid-frame through the last handshake
         if (beats == 10) begin
            start_s = 1'b1; rc = 32'h1234_5678; ic = 32'h0ABC_DEF0; zoom = 5'd3;
         end
         tick;
      end
      start_s = 1'b0;
      n_cmp++;
      if (beats != 24) begin n_err++; $display("FAIL busy_start_beats got %0d want 24", beats); end
      n_cmp++;
      if (busy_s !== 1'b0 || valid_s !== 1'b0) begin
         n_err++; $display("FAIL busy_start_end got busy=%b valid=%b want 0 0", busy_s, valid_s);
      end
      extra = 0;
      for (int c = 0; c < 40; c++) begin
         tick;
         if (busy_s !== 1'b0 || valid_s !== 1'b0) extra++;
      end
      n_cmp++;
      if (extra != 0) begin n_err++; $display("FAIL busy_start_second got %0d busy cycles want 0", extra); end
   endtask

   initial begin
      test_reset;
      test_origin;
      test_reset_mid;
      test_backpressure;
      test_full_frame;
      test_start_ignored;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
